mem_ctrl_nch: RTL and testbench
===============================

Name: mem_ctrl_nch

Overview:
Parametrised N-channel, byte-serial memory controller. It is the successor to the fixed two-port (instruction/data) cache front end that sits between the requesters (Fetcher, LSB, future prefetch/IO ports) and the 8-bit RAM/IO bus.
- Arbitrates requesters round-robin.
- Serialises 1/2/4-byte accesses onto the byte bus.
- Sign- or zero-extends read data.
- Honours UART back-pressure.
- Aborts in-flight speculative reads on pipeline clear.

Parameters:
NUM_CH, 2, number of requester channels (1..8)
FLUSH_MASK, 2'b01, bit i set: channel i reads are cancelled by clear_in
IO_SEL_HI, 17, upper bit of the IO-select field; address is IO when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes block
clear_in  input  1  pipeline flush (ROB mispredict)
req_in  input  NUM_CH  request valid per channel, level, held until done
wr_in  input  NUM_CH  1 = write
signed_in  input  NUM_CH  1 = sign-extend read
size_in  input  2*NUM_CH  0 byte, 1 half, 2 word (3 illegal, treated as word)
addr_in  input  32*NUM_CH  byte address
wdata_in  input  32*NUM_CH  write data, little-endian
grant_out  output  NUM_CH  one-hot, high while channel's op is active
done_out  output  NUM_CH  one-cycle pulse, op complete
rdata_out  output  32  extended read data, valid with done_out
mem_din  input  8  RAM/IO read byte (valid cycle after address)
mem_dout  output  8  write byte
mem_a  output  32  byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART TX full

Behaviour:
Reset values:
- mem_a=0, mem_dout=0, mem_wr=0.
- grant_out=0, done_out=0, rdata_out=0.
- State IDLE; round-robin pointer=0.

States: IDLE, READ, WRITE.

IDLE:
- Among req_in & ~done-this-cycle, pick the first asserted channel at or after the pointer, wrapping.
- In a cycle with clear_in high, flushable channels are excluded from the pick.
- On a grant: latch addr/size/wdata/signed, set grant_out, go to READ or WRITE, and drive the first byte in the same cycle.
- Pointer = granted index + 1 (mod NUM_CH).

READ (N = 1/2/4 bytes):
- Byte k address issued in grant cycle + k.
- mem_din captured one cycle after each address, into byte lane k.
- done_out pulses in the cycle after the last capture, so latency from grant is N+1 cycles.
- Return to IDLE with done_out; a new grant is possible the same cycle.

WRITE:
- Byte k drives mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr=1.
- done_out pulses with the last byte; latency is N cycles.

IO stall:
- Applies when the write address has the IO select bits = 11 and io_buffer_full=1.
- Hold mem_wr=0, do not advance the byte counter, retry every cycle.
- Reads are never stalled by io_buffer_full.

rdata extension:
- byte: signed ? {24{b0[7]}} : 24'b0 concatenated with b0.
- half: same rule using b1[7].
- word: raw value.

clear_in while a flushable channel is in READ:
- Next cycle: IDLE, grant_out=0, no done_out.
- A late mem_din is ignored.
- Writes and non-flushable reads are never aborted.

rdy_in=0:
- All registers hold and mem_wr is forced to 0.
- The memory holds its output, so capture resumes correctly.

Address arithmetic:
- addr+k is 32-bit wrap-around.
- No alignment check; misaligned access is serialised bytewise.

A requester dropping req_in mid-op is ignored; the op completes.
rst_in mid-op returns the block to the reset state in the next cycle with no done_out.

Decomposition:
Shared package holds:
- MEM_SIZE_BYTE=0, MEM_SIZE_HALF=1, MEM_SIZE_WORD=2.
- State encodings.
- The IO-select constant 2'b11.

Sub-module rr_arbiter_n (NUM_CH-wide, pointer in, one-hot grant out) is natural and reused by future RS/LSB issue logic.

Test Plan:
1. ch0 word read at 0x1000, RAM bytes 11 22 33 44 -> mem_a 0x1000..0x1003 on consecutive cycles; done_out[0] at grant+5; rdata 0x44332211.
2. ch1 byte read at 0x20, byte 0x80: signed_in=1 -> 0xFFFFFF80; signed_in=0 -> 0x00000080. Half read 0x80FF signed -> 0xFFFF80FF.
3. ch0 and ch1 request together (pointer 0) -> ch0 served, then ch1. Both again -> order ch0 then ch1 again, because the pointer wraps to 0 after ch1.
4. ch1 byte write 0x41 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 with mem_dout=0x41; done_out[1] in that same cycle.
5. ch0 (flushable) word read, clear_in at grant+2 while ch1 is waiting -> no done_out[0]; ch1 granted at grant+3 or later; rdata unaffected.
6. rdy_in low for 4 cycles mid word-write -> no mem_wr during the pause; remaining bytes resume in order; total done latency = 4+4 cycles.

Source files
------------

// File: rtl/mem_ctrl_nch_pkg.sv
// Shared encodings for the N-channel byte-serial memory controller and its
// arbiter: access sizes, FSM states and the IO-select pattern.
package mem_ctrl_nch_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF = 2'd1;
    localparam logic [1:0] MEM_SIZE_WORD = 2'd2;

    localparam logic [1:0] IO_SEL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Size code 3 is illegal and is serviced as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            MEM_SIZE_BYTE: return 3'd1;
            MEM_SIZE_HALF: return 3'd2;
            MEM_SIZE_WORD: return 3'd4;
            default:       return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant plus the encoded winner index.
module rr_arbiter_n #(
    parameter int NUM_CH = 2,
    parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [PTR_W-1:0]  idx,
    output logic              any
);

    int               pos;
    logic [PTR_W-1:0] sel;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            sel = PTR_W'(pos);
            if (!any && req[sel]) begin
                any        = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl_nch.sv
// N-channel byte-serial memory controller: round-robin grant, 1/2/4-byte
// serialisation onto an 8-bit RAM/IO bus, read extension and flush abort.
module mem_ctrl_nch
    import mem_ctrl_nch_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter logic [NUM_CH-1:0] FLUSH_MASK = NUM_CH'(2'b01),
    parameter int                IO_SEL_HI  = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic [NUM_CH-1:0]     req_in,
    input  logic [NUM_CH-1:0]     wr_in,
    input  logic [NUM_CH-1:0]     signed_in,
    input  logic [2*NUM_CH-1:0]   size_in,
    input  logic [32*NUM_CH-1:0]  addr_in,
    input  logic [32*NUM_CH-1:0]  wdata_in,
    output logic [NUM_CH-1:0]     grant_out,
    output logic [NUM_CH-1:0]     done_out,
    output logic [31:0]           rdata_out,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [31:0]           mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic logic [7:0] lane_get(input logic [31:0] w, input logic [1:0] lane);
        case (lane)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    function automatic logic [31:0] lane_put(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend_rd(input logic [31:0] raw, input logic [1:0] size,
                                              input logic sgn);
        case (size)
            MEM_SIZE_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
            MEM_SIZE_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
            default:       return raw;
        endcase
    endfunction

    logic [31:0] addr_ch  [NUM_CH];
    logic [31:0] wdata_ch [NUM_CH];
    logic [1:0]  size_ch  [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign addr_ch[g]  = addr_in[32*g +: 32];
        assign wdata_ch[g] = wdata_in[32*g +: 32];
        assign size_ch[g]  = size_in[2*g +: 2];
    end

    state_t              state, state_nx;
    logic [PTR_W-1:0]    ptr, ptr_nx, ch, ch_nx;
    logic [2:0]          cnt, cnt_nx, cnt_inc, nb;
    logic [1:0]          lane_rd, size_q, size_nx;
    logic                sgn_q, sgn_nx, wr_q, wr_nx;
    logic [31:0]         addr_q, addr_nx, wdata_q, wdata_nx, buf_q, buf_nx;
    logic [31:0]         rdata_q, rdata_nx, a_q, a_nx;
    logic [7:0]          dout_q, dout_nx;
    logic [NUM_CH-1:0]   grant_q, grant_nx, done_q, done_nx;

    logic [NUM_CH-1:0]   pick_req, pick_grant;
    logic [PTR_W-1:0]    pick_idx;
    logic                pick_any, stall, fire, wr_last;

    assign nb      = size_bytes(size_q);
    assign cnt_inc = cnt + 3'd1;
    // Capture lags the issued address by one cycle.
    assign lane_rd = cnt[1:0] - 2'd1;

    assign stall   = (a_q[IO_SEL_HI -: 2] == IO_SEL) && io_buffer_full;
    assign fire    = rdy_in && !stall;
    assign wr_last = (state == ST_WRITE) && fire && (cnt == nb - 3'd1);

    assign grant_out = grant_q;
    assign rdata_out = rdata_q;
    assign mem_a     = a_q;
    assign mem_dout  = dout_q;
    assign mem_wr    = wr_q && fire;
    assign done_out  = (done_q & {NUM_CH{rdy_in}}) | ({NUM_CH{wr_last}} & grant_q);

    // A channel whose done is visible this cycle still holds req; skip it.
    assign pick_req = req_in & ~done_out & (clear_in ? ~FLUSH_MASK : {NUM_CH{1'b1}});

    rr_arbiter_n #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req    (pick_req),
        .ptr    (ptr),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        ch_nx    = ch;
        cnt_nx   = cnt;
        size_nx  = size_q;
        sgn_nx   = sgn_q;
        wr_nx    = wr_q;
        addr_nx  = addr_q;
        wdata_nx = wdata_q;
        buf_nx   = buf_q;
        rdata_nx = rdata_q;
        a_nx     = a_q;
        dout_nx  = dout_q;
        grant_nx = grant_q;
        done_nx  = '0;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    ch_nx    = pick_idx;
                    ptr_nx   = (pick_idx == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
                    addr_nx  = addr_ch[pick_idx];
                    wdata_nx = wdata_ch[pick_idx];
                    size_nx  = size_ch[pick_idx];
                    sgn_nx   = signed_in[pick_idx];
                    grant_nx = pick_grant;
                    cnt_nx   = '0;
                    a_nx     = addr_ch[pick_idx];
                    if (wr_in[pick_idx]) begin
                        state_nx = ST_WRITE;
                        dout_nx  = wdata_ch[pick_idx][7:0];
                        wr_nx    = 1'b1;
                    end else begin
                        state_nx = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (clear_in && FLUSH_MASK[ch]) begin
                    state_nx = ST_IDLE;
                    grant_nx = '0;
                end else begin
                    if (cnt != 3'd0) begin
                        buf_nx = lane_put(buf_q, lane_rd, mem_din);
                    end
                    if (cnt == nb) begin
                        state_nx = ST_IDLE;
                        grant_nx = '0;
                        done_nx  = grant_q;
                        rdata_nx = extend_rd(buf_nx, size_q, sgn_q);
                    end else begin
                        cnt_nx = cnt_inc;
                        if (cnt_inc < nb) begin
                            a_nx = addr_q + 32'(cnt_inc);
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (fire) begin
                    if (wr_last) begin
                        state_nx = ST_IDLE;
                        wr_nx    = 1'b0;
                        grant_nx = '0;
                    end else begin
                        cnt_nx  = cnt_inc;
                        a_nx    = addr_q + 32'(cnt_inc);
                        dout_nx = lane_get(wdata_q, cnt_inc[1:0]);
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            ch      <= '0;
            cnt     <= '0;
            size_q  <= MEM_SIZE_BYTE;
            sgn_q   <= 1'b0;
            wr_q    <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            a_q     <= '0;
            dout_q  <= '0;
        end else if (rdy_in) begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            ch      <= ch_nx;
            cnt     <= cnt_nx;
            size_q  <= size_nx;
            sgn_q   <= sgn_nx;
            wr_q    <= wr_nx;
            grant_q <= grant_nx;
            done_q  <= done_nx;
            rdata_q <= rdata_nx;
            a_q     <= a_nx;
            dout_q  <= dout_nx;
        end
    end

    // Latched request fields and the assembly buffer carry no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
            buf_q   <= buf_nx;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_nch.sv
// Directed bench for mem_ctrl_nch with a registered byte ROM (data valid the
// cycle after the address) and a log of bus writes.
module tb_mem_ctrl_nch;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clear_in, io_buffer_full;
    logic [1:0]  req_in, wr_in, signed_in, grant_out, done_out;
    logic [3:0]  size_in;
    logic [63:0] addr_in, wdata_in;
    logic [31:0] rdata_out, mem_a;
    logic [7:0]  mem_din, mem_dout;
    logic        mem_wr;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] wr_a [16];
    logic [7:0]  wr_d [16];
    int          wr_n = 0;

    mem_ctrl_nch dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .req_in         (req_in),
        .wr_in          (wr_in),
        .signed_in      (signed_in),
        .size_in        (size_in),
        .addr_in        (addr_in),
        .wdata_in       (wdata_in),
        .grant_out      (grant_out),
        .done_out       (done_out),
        .rdata_out      (rdata_out),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 8'h11;
            32'h0000_1001: return 8'h22;
            32'h0000_1002: return 8'h33;
            32'h0000_1003: return 8'h44;
            32'h0000_0020: return 8'h80;
            32'h0000_0040: return 8'hFF;
            32'h0000_0041: return 8'h80;
            32'h0000_0100: return 8'hA5;
            32'h0000_0104: return 8'h5A;
            32'hFFFF_FFFF: return 8'h34;
            32'h0000_0000: return 8'h12;
            default:       return a[7:0] ^ 8'h5C;
        endcase
    endfunction

    always @(posedge clk_in) begin
        if (rdy_in) begin
            mem_din <= rom(mem_a);
        end
        if (mem_wr) begin
            wr_a[wr_n[3:0]] <= mem_a;
            wr_d[wr_n[3:0]] <= mem_dout;
            wr_n            <= wr_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_in);
    endtask

    task automatic set_ch(input logic ch, input logic wr, input logic sgn, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
        req_in[ch]    = 1'b1;
        wr_in[ch]     = wr;
        signed_in[ch] = sgn;
        if (ch) begin
            size_in[3:2]    = size;
            addr_in[63:32]  = addr;
            wdata_in[63:32] = wdata;
        end else begin
            size_in[1:0]    = size;
            addr_in[31:0]   = addr;
            wdata_in[31:0]  = wdata;
        end
    endtask

    task automatic do_read(input logic ch, input logic sgn, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] exp, input string tag);
        int         n;
        logic [1:0] oh;
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        oh = ch ? 2'b10 : 2'b01;
        tick();
        set_ch(ch, 1'b0, sgn, size, addr, 32'h0);
        tick(); smp();
        chk($sformatf("%s_grant", tag), 32'(grant_out), 32'(oh));
        chk($sformatf("%s_a0", tag), mem_a, addr);
        for (int k = 1; k < n; k++) begin
            tick(); smp();
            chk($sformatf("%s_a%0d", tag, k), mem_a, addr + 32'(k));
        end
        tick(); smp();
        chk($sformatf("%s_early_done", tag), 32'(done_out), 32'h0);
        tick(); smp();
        chk($sformatf("%s_done", tag), 32'(done_out), 32'(oh));
        chk($sformatf("%s_rdata", tag), rdata_out, exp);
        tick();
        req_in[ch] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full = 1'b0;
        req_in = '0; wr_in = '0; signed_in = '0; size_in = '0; addr_in = '0; wdata_in = '0;
        repeat (3) tick();
        smp();
        chk("rst_grant", 32'(grant_out), 32'h0);
        chk("rst_done", 32'(done_out), 32'h0);
        chk("rst_rdata", rdata_out, 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_dout", 32'(mem_dout), 32'h0);
        chk("rst_wr", 32'(mem_wr), 32'h0);
        tick();
        rst_in = 1'b0;

        // Word read, latency N+1.
        do_read(1'b0, 1'b0, 2'd2, 32'h1000, 32'h4433_2211, "t1");

        // Reset in the middle of a read: no done, reset state next cycle.
        tick();
        set_ch(1'b0, 1'b0, 1'b0, 2'd2, 32'h1000, 32'h0);
        tick(); smp();
        chk("mrst_grant", 32'(grant_out), 32'h1);
        tick();
        rst_in = 1'b1;
        smp();
        tick();
        rst_in = 1'b0;
        req_in[0] = 1'b0;
        smp();
        chk("mrst_grant0", 32'(grant_out), 32'h0);
        chk("mrst_mem_a", mem_a, 32'h0);
        chk("mrst_rdata", rdata_out, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick(); smp();
            chk("mrst_nodone", 32'(done_out), 32'h0);
        end

        // Byte and half reads with extension.
        do_read(1'b1, 1'b1, 2'd0, 32'h20, 32'hFFFF_FF80, "t2s");
        do_read(1'b1, 1'b0, 2'd0, 32'h20, 32'h0000_0080, "t2u");
        do_read(1'b1, 1'b1, 2'd1, 32'h40, 32'hFFFF_80FF, "t2h");

        // Simultaneous requests: ch0 then ch1, twice.
        for (int r = 0; r < 2; r++) begin
            tick();
            set_ch(1'b0, 1'b0, 1'b0, 2'd0, 32'h100, 32'h0);
            set_ch(1'b1, 1'b0, 1'b0, 2'd0, 32'h104, 32'h0);
            tick(); smp();
            chk($sformatf("rr%0d_g0", r), 32'(grant_out), 32'h1);
            tick(); smp();
            tick(); smp();
            chk($sformatf("rr%0d_d0", r), 32'(done_out), 32'h1);
            chk($sformatf("rr%0d_r0", r), rdata_out, 32'h0000_00A5);
            tick();
            req_in[0] = 1'b0;
            smp();
            chk($sformatf("rr%0d_g1", r), 32'(grant_out), 32'h2);
            tick(); smp();
            tick(); smp();
            chk($sformatf("rr%0d_d1", r), 32'(done_out), 32'h2);
            chk($sformatf("rr%0d_r1", r), rdata_out, 32'h0000_005A);
            tick();
            req_in[1] = 1'b0;
        end

        // Half read wrapping past the top of the address space.
        do_read(1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0000_1234, "wrap");

        // IO write held off by a full UART buffer for three cycles.
        tick();
        set_ch(1'b1, 1'b1, 1'b0, 2'd0, 32'h0003_0000, 32'h41);
        tick();
        io_buffer_full = 1'b1;
        smp();
        chk("io_grant", 32'(grant_out), 32'h2);
        chk("io_wr_c0", 32'(mem_wr), 32'h0);
        for (int k = 1; k < 3; k++) begin
            tick(); smp();
            chk("io_wr_stall", 32'(mem_wr), 32'h0);
            chk("io_done_stall", 32'(done_out), 32'h0);
        end
        tick();
        io_buffer_full = 1'b0;
        smp();
        chk("io_wr", 32'(mem_wr), 32'h1);
        chk("io_dout", 32'(mem_dout), 32'h41);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_done", 32'(done_out), 32'h2);
        tick();
        req_in[1] = 1'b0;
        wr_in[1]  = 1'b0;
        smp();
        chk("io_wr_after", 32'(mem_wr), 32'h0);
        chk("io_grant_after", 32'(grant_out), 32'h0);

        // Flush of ch0 read while ch1 waits.
        tick();
        set_ch(1'b0, 1'b0, 1'b0, 2'd2, 32'h200, 32'h0);
        set_ch(1'b1, 1'b0, 1'b0, 2'd0, 32'h20, 32'h0);
        tick(); smp();
        chk("fl_g0", 32'(grant_out), 32'h1);
        tick(); smp();
        tick();
        clear_in = 1'b1;
        smp();
        chk("fl_g0_c2", 32'(grant_out), 32'h1);
        tick();
        clear_in  = 1'b0;
        req_in[0] = 1'b0;
        smp();
        chk("fl_grant0", 32'(grant_out), 32'h0);
        chk("fl_nodone", 32'(done_out), 32'h0);
        chk("fl_rdata", rdata_out, 32'h0000_1234);
        tick(); smp();
        chk("fl_g1", 32'(grant_out), 32'h2);
        chk("fl_nodone4", 32'(done_out), 32'h0);
        tick(); smp();
        chk("fl_nodone5", 32'(done_out), 32'h0);
        tick(); smp();
        chk("fl_d1", 32'(done_out), 32'h2);
        chk("fl_r1", rdata_out, 32'h0000_0080);
        tick();
        req_in[1] = 1'b0;

        // Word write paused by rdy_in low for four cycles.
        tick();
        set_ch(1'b0, 1'b1, 1'b0, 2'd2, 32'h300, 32'hDDCC_BBAA);
        tick(); smp();
        chk("rdy_wr0", 32'(mem_wr), 32'h1);
        chk("rdy_a0", mem_a, 32'h300);
        chk("rdy_d0", 32'(mem_dout), 32'hAA);
        tick(); smp();
        chk("rdy_a1", mem_a, 32'h301);
        chk("rdy_d1", 32'(mem_dout), 32'hBB);
        tick();
        rdy_in = 1'b0;
        smp();
        chk("rdy_pause_wr", 32'(mem_wr), 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick(); smp();
            chk("rdy_pause_wr", 32'(mem_wr), 32'h0);
            chk("rdy_pause_done", 32'(done_out), 32'h0);
        end
        tick();
        rdy_in = 1'b1;
        smp();
        chk("rdy_a2", mem_a, 32'h302);
        chk("rdy_d2", 32'(mem_dout), 32'hCC);
        chk("rdy_wr2", 32'(mem_wr), 32'h1);
        chk("rdy_early_done", 32'(done_out), 32'h0);
        tick(); smp();
        chk("rdy_a3", mem_a, 32'h303);
        chk("rdy_d3", 32'(mem_dout), 32'hDD);
        chk("rdy_done", 32'(done_out), 32'h1);
        tick();
        req_in[0] = 1'b0;
        wr_in[0]  = 1'b0;
        smp();
        chk("rdy_wr_after", 32'(mem_wr), 32'h0);

        chk("wlog_n", 32'(wr_n), 32'd5);
        chk("wlog_a0", wr_a[0], 32'h0003_0000);
        chk("wlog_d0", 32'(wr_d[0]), 32'h41);
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("wlog_a%0d", k), wr_a[k], 32'h300 + 32'(k - 1));
        end
        chk("wlog_d1", 32'(wr_d[1]), 32'hAA);
        chk("wlog_d2", 32'(wr_d[2]), 32'hBB);
        chk("wlog_d3", 32'(wr_d[3]), 32'hCC);
        chk("wlog_d4", 32'(wr_d[4]), 32'hDD);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
